// File: rtl/raddr_channel_pkg.sv
// Shared constants and state encoding for the AXI read-address stage.
// Imported by raddr_channel.
package raddr_channel_pkg;
  localparam int BEAT_BYTES = 128;
  localparam int PARAM_BEATS = 6;
  localparam int MB_BEATS = 3;
  localparam logic [2:0] ARSIZE_128B = 3'b111;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;
endpackage

// File: rtl/raddr_channel.sv
// AXI read-address stage: splits one job into credit-limited AR bursts
// that never cross a 4 KB boundary, and reports when the last beat lands.
module raddr_channel
  import raddr_channel_pkg::*;
#(
  parameter int ID_WIDTH = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int BURST_BEATS = 8,
  parameter int MAX_OUT_BEATS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_pulse,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [15:0]           mb_num,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic                  m_axi_rready,
  output logic                  busy,
  output logic                  rd_done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [19:0]           total;
  logic [19:0]           issue_ptr;
  logic [19:0]           rx_cnt;
  logic [6:0]            out_cnt;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [5:0]            to_4k;
  logic [5:0]            nb;
  logic                  credit_ok;
  logic                  ar_fire;
  logic                  r_fire;
  logic [19:0]           issue_next;
  logic [19:0]           rx_next;
  logic [6:0]            out_next;

  function automatic logic [5:0] burst_len(
    input logic [19:0] left,
    input logic [5:0]  room
  );
    logic [19:0] n;
    n = 20'(BURST_BEATS);
    if (left < n) n = left;
    if ({14'd0, room} < n) n = {14'd0, room};
    return 6'(n);
  endfunction

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = ARSIZE_128B;
  assign m_axi_arburst = ARBURST_INCR;

  assign cur_addr   = base + ADDR_WIDTH'({issue_ptr, 7'd0});
  assign to_4k      = 6'd32 - 6'(cur_addr[11:7]);
  assign nb         = burst_len(total - issue_ptr, to_4k);
  // Registered out_cnt only: same-cycle returns free credit next cycle.
  assign credit_ok  = ({1'b0, out_cnt} + {2'b0, nb}) <= 8'(MAX_OUT_BEATS);
  assign ar_fire    = m_axi_arvalid & m_axi_arready;
  assign r_fire     = m_axi_rvalid & m_axi_rready;
  assign issue_next = issue_ptr + 20'(m_axi_arlen) + 20'd1;
  assign rx_next    = rx_cnt + 20'(r_fire);
  assign out_next   = out_cnt
                    + (ar_fire ? 7'(m_axi_arlen + 8'd1) : 7'd0)
                    - 7'(r_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      base          <= '0;
      total         <= '0;
      issue_ptr     <= '0;
      rx_cnt        <= '0;
      out_cnt       <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
      busy          <= 1'b0;
      rd_done       <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_pulse) begin
            state     <= ISSUE;
            base      <= src_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
            total     <= 20'(PARAM_BEATS) + 20'(mb_num) * 20'(MB_BEATS);
            issue_ptr <= '0;
            rx_cnt    <= '0;
            out_cnt   <= '0;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          rx_cnt  <= rx_next;
          out_cnt <= out_next;
          if (ar_fire) begin
            m_axi_arvalid <= 1'b0;
            issue_ptr     <= issue_next;
            if (issue_next == total) state <= DRAIN;
          end else if (!m_axi_arvalid && credit_ok) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= cur_addr;
            m_axi_arlen   <= 8'(nb - 6'd1);
          end
        end
        DRAIN: begin
          rx_cnt  <= rx_next;
          out_cnt <= out_next;
          if (rx_next == total) begin
            rd_done <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
